// File: rtl/instr_data_arbiter.sv
// instr_data_arbiter
// Shares one memory port between the instruction-fetch path and the
// load/store path. Requests are granted from IDLE, the request is latched
// into the port registers, and the port is held steady until memory drops
// mem_busy (or the busy-wait budget runs out).
//
// Ports
//   clk                    system clock, rising edge
//   nRST                   synchronous active-low reset
//   fetch_req, pc_addr     fetch request / address, held until iready
//   dmem_read, dmem_write  load / store request, held until dready
//   dmem_addr, dmem_wdata  data address / store data
//   mem_busy, mem_rdata    memory wait / read data
//   mem_read, mem_write    shared port strobes (never both high)
//   mem_addr, mem_wdata    shared port address / write data
//   iready, instr          fetch-complete pulse / last fetched instruction
//   dready, drdata         data-complete pulse / last load data
//   err                    sticky timeout flag
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no transaction; grants when no ready pulse is out
// IFETCH   | instruction read on the port, waiting on mem_busy
// DACCESS  | load or store on the port, waiting on mem_busy
module instr_data_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        fetch_req,
  input  logic [31:0] pc_addr,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        mem_busy,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        iready,
  output logic [31:0] instr,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IFETCH  = 2'd1;
  localparam logic [1:0] S_DACCESS = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_data_q, last_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        iready_q, iready_d;
  logic        dready_q, dready_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] drdata_q, drdata_d;
  logic        err_q, err_d;

  logic data_req;
  assign data_req = dmem_read | dmem_write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    instr_d     = instr_q;
    drdata_d    = drdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // A ready pulse means the requester has not yet dropped its request,
        // so that cycle's requests are stale.
        if (!iready_q && !dready_q) begin
          if (data_req && !(last_data_q && fetch_req)) begin
            state_d     = S_DACCESS;
            last_data_d = 1'b1;
            cnt_d       = 8'd0;
            mem_addr_d  = dmem_addr;
            // read+write together is a store
            mem_write_d = dmem_write;
            mem_read_d  = ~dmem_write;
            mem_wdata_d = dmem_write ? dmem_wdata : 32'd0;
          end else if (fetch_req) begin
            state_d     = S_IFETCH;
            last_data_d = 1'b0;
            cnt_d       = 8'd0;
            mem_addr_d  = pc_addr;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_wdata_d = 32'd0;
          end
        end
      end

      S_IFETCH, S_DACCESS: begin
        if (!mem_busy || (cnt_q == TIMEOUT_C)) begin
          state_d     = S_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          if (state_q == S_IFETCH) iready_d = 1'b1;
          else                     dready_d = 1'b1;
          if (mem_busy) begin
            // budget exhausted: abort without capturing data
            err_d = 1'b1;
          end else if (state_q == S_IFETCH) begin
            instr_d = mem_rdata;
          end else if (mem_read_q) begin
            drdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      last_data_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      instr_q     <= 32'd0;
      drdata_q    <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
      instr_q     <= instr_d;
      drdata_q    <= drdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign iready    = iready_q;
  assign dready    = dready_q;
  assign instr     = instr_q;
  assign drdata    = drdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_data_arbiter.sv
// Bench for instr_data_arbiter: directed transactions push their expected
// completion into a queue; a monitor pops on every iready/dready pulse.
module tb_instr_data_arbiter;

  logic        clk = 1'b0;
  logic        nRST;
  logic        fetch_req;
  logic [31:0] pc_addr;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        mem_busy;
  logic [31:0] mem_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic        iready, dready, err;
  logic [31:0] instr, drdata;

  always #5 clk = ~clk;

  instr_data_arbiter #(.TIMEOUT(255)) dut (
    .clk(clk), .nRST(nRST),
    .fetch_req(fetch_req), .pc_addr(pc_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .iready(iready), .instr(instr),
    .dready(dready), .drdata(drdata), .err(err)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] instr;
    logic [31:0] drdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model of the visible result registers
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_drdata = 32'd0;
  logic        m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic capture,
                          input logic [31:0] rdata, input logic timeout);
    exp_t e;
    if (timeout) m_err = 1'b1;
    else if (capture) begin
      if (is_d) m_drdata = rdata;
      else      m_instr  = rdata;
    end
    e.is_d = is_d; e.instr = m_instr; e.drdata = m_drdata; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (iready || dready) begin
      chk1("ready_exclusive", iready & dready, 1'b0);
      chk1("strobe_exclusive", mem_read & mem_write, 1'b0);
      if (exp_q.size() == 0) begin
        chk1("unexpected_ready", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk1("ready_kind_dready", dready, e.is_d);
        chk("instr", instr, e.instr);
        chk("drdata", drdata, e.drdata);
        chk1("err", err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits for the port strobe to appear; n = rising edges taken
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(mem_read || mem_write) && n < 10);
    if (!(mem_read || mem_write)) chk1("grant_timeout", 1'b0, 1'b1);
  endtask

  // waits for the selected ready pulse; n = falling edges taken
  task automatic wait_rdy(input logic want_d, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      seen = want_d ? dready : iready;
    end
    if (!seen) chk1("ready_wait_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) tick();
    m_instr = 32'd0; m_drdata = 32'd0; m_err = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    fetch_req = 0; pc_addr = 0; dmem_read = 0; dmem_write = 0;
    dmem_addr = 0; dmem_wdata = 0; mem_busy = 0; mem_rdata = 0;

    // reset
    do_reset();
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk1("rst_iready", iready, 1'b0);
    chk1("rst_dready", dready, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_drdata", drdata, 32'd0);
    chk1("rst_err", err, 1'b0);
    nRST = 1'b1;
    repeat (3) tick();
    chk1("idle_mem_read", mem_read, 1'b0);
    chk1("idle_mem_write", mem_write, 1'b0);
    chk1("idle_iready", iready, 1'b0);

    // single fetch, no wait states, minimum latency
    fetch_req = 1; pc_addr = 32'h4; mem_rdata = 32'h13;
    push_exp(1'b0, 1'b1, 32'h13, 1'b0);
    wait_grant(n);
    chk("fetch_grant_latency", n, 1);
    chk1("fetch_mem_read", mem_read, 1'b1);
    chk1("fetch_mem_write", mem_write, 1'b0);
    chk("fetch_mem_addr", mem_addr, 32'h4);
    chk("fetch_mem_wdata", mem_wdata, 32'h0);
    wait_rdy(1'b0, n);
    chk("fetch_ready_latency", n, 2);
    fetch_req = 0;
    tick();
    chk1("fetch_done_strobe", mem_read, 1'b0);

    // contention and alternation over four grants
    do_reset();
    nRST = 1;
    fetch_req = 1; pc_addr = 32'h40;
    dmem_read = 1; dmem_addr = 32'h100; mem_rdata = 32'hAAAA0001;
    push_exp(1'b1, 1'b1, 32'hAAAA0001, 1'b0);
    wait_grant(n);
    chk("g1_data_addr", mem_addr, 32'h100);
    chk1("g1_data_read", mem_read, 1'b1);
    wait_rdy(1'b1, n);
    dmem_read = 0; mem_rdata = 32'hBBBB0002;
    push_exp(1'b0, 1'b1, 32'hBBBB0002, 1'b0);
    wait_grant(n);
    chk("g2_idle_gap", n, 2);
    chk("g2_fetch_addr", mem_addr, 32'h40);
    wait_rdy(1'b0, n);
    pc_addr = 32'h44; dmem_read = 1; dmem_addr = 32'h104; mem_rdata = 32'hCCCC0003;
    push_exp(1'b1, 1'b1, 32'hCCCC0003, 1'b0);
    wait_grant(n);
    chk("g3_data_addr", mem_addr, 32'h104);
    wait_rdy(1'b1, n);
    dmem_read = 0; mem_rdata = 32'hDDDD0004;
    push_exp(1'b0, 1'b1, 32'hDDDD0004, 1'b0);
    wait_grant(n);
    chk("g4_fetch_addr", mem_addr, 32'h44);
    wait_rdy(1'b0, n);
    fetch_req = 0;

    // store with three wait states; inputs change mid-transaction
    dmem_write = 1; dmem_addr = 32'h200; dmem_wdata = 32'hDEADBEEF;
    mem_busy = 1; mem_rdata = 32'h12345678;
    push_exp(1'b1, 1'b0, 32'h0, 1'b0);
    wait_grant(n);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin dmem_addr = 32'h999; dmem_wdata = 32'h0; end
      if (k == 3) mem_busy = 0;
      chk1("st_mem_write", mem_write, 1'b1);
      chk1("st_mem_read", mem_read, 1'b0);
      chk("st_mem_addr", mem_addr, 32'h200);
      chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk1("st_no_dready", dready, 1'b0);
      tick();
    end
    chk1("st_dready", dready, 1'b1);
    chk1("st_strobe_off", mem_write, 1'b0);
    dmem_write = 0;
    tick();

    // timeout: busy stuck; TIMEOUT busy cycles are counted, the next busy
    // cycle aborts, so the strobe is up for TIMEOUT+1 cycles
    fetch_req = 1; pc_addr = 32'h80; mem_busy = 1; mem_rdata = 32'h55;
    push_exp(1'b0, 1'b0, 32'h0, 1'b1);
    wait_grant(n);
    cnt = 0;
    while (mem_read && cnt < 400) begin
      if (cnt == 0) chk1("to_err_before", err, 1'b0);
      cnt++;
      tick();
    end
    chk("to_strobe_cycles", cnt, 256);
    chk1("to_iready", iready, 1'b1);
    fetch_req = 0; mem_busy = 0;
    tick();
    fetch_req = 1; pc_addr = 32'h84; mem_rdata = 32'h66;
    push_exp(1'b0, 1'b1, 32'h66, 1'b0);
    wait_grant(n);
    chk("to_next_addr", mem_addr, 32'h84);
    wait_rdy(1'b0, n);
    fetch_req = 0;
    tick();

    // reset in the middle of a load
    dmem_read = 1; dmem_addr = 32'h300; mem_busy = 1; mem_rdata = 32'h77;
    wait_grant(n);
    chk("mid_addr", mem_addr, 32'h300);
    tick();
    tick();
    nRST = 0;
    tick();
    m_instr = 32'd0; m_drdata = 32'd0; m_err = 1'b0;
    chk1("mid_rst_read", mem_read, 1'b0);
    chk1("mid_rst_write", mem_write, 1'b0);
    chk1("mid_rst_dready", dready, 1'b0);
    chk("mid_rst_drdata", drdata, 32'd0);
    chk1("mid_rst_err", err, 1'b0);
    dmem_read = 0; mem_busy = 0;
    tick();
    nRST = 1;
    repeat (3) tick();
    chk1("mid_after_read", mem_read, 1'b0);
    chk1("mid_after_dready", dready, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
